regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Owns the single write port of the register file. After reset it clears x1..x(2^ADDRESS_LEN-1)
//  through that port, then shares the port between NUM_REQ write-back requesters with
//  valid/ready handshakes and round-robin arbitration.
//  Sits between the ALU, load and CSR write-back paths and the register file. Drives
//  reg_write, wr_addr and data.
// PARAMETERS
//  ADDRESS_LEN  5   register address width; register file holds 2**ADDRESS_LEN entries
//  N            32  data width
//  NUM_REQ      3   number of write-back requesters (2..8)
// PORTS
//  clk          in   1                 clock, all state on rising edge
//  rst          in   1                 synchronous, active-high reset
//  req_valid    in   NUM_REQ           bit i: requester i has a write pending
//  req_addr     in   NUM_REQ*ADDRESS_LEN  requester i destination, bits [i*ADDRESS_LEN +: ADDRESS_LEN]
//  req_data     in   NUM_REQ*N         requester i write data, bits [i*N +: N]
//  req_ready    out  NUM_REQ           bit i: requester i accepted this cycle (one-hot or zero)
//  rf_reg_write out  1                 register-file write enable (registered)
//  rf_wr_addr   out  ADDRESS_LEN       register-file write address (registered)
//  rf_data      out  N                 register-file write data (registered)
//  init_done    out  1                 clear sequence complete; arbitration active
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=INIT, clr_cnt=1, rr_ptr=0, rf_reg_write=0, rf_wr_addr=0,
//    rf_data=0, init_done=0. req_ready=0 whenever init_done=0.
//  - rst asserted at any time, including mid-INIT or mid-RUN, aborts everything and restarts
//    INIT from address 1. Any in-flight accepted request is lost.
//  - INIT: edge k after reset release (k=1..2^ADDRESS_LEN-1) loads rf_reg_write=1,
//    rf_wr_addr=k, rf_data=0. After address 2^ADDRESS_LEN-1 is loaded, the next edge loads
//    rf_reg_write=0 and init_done=1, and state goes to RUN. Address 0 is never written.
//  - RUN: grant = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo
//    NUM_REQ.
//    - req_ready[grant]=1, combinational from req_valid and rr_ptr. All other bits are 0.
//      No grant when no valid.
//    - Handshake: a transfer happens when req_valid[i] & req_ready[i] at an edge.
//    - A requester that is not granted holds valid, addr and data stable until granted.
//  - On a transfer, the next edge loads rf_wr_addr=req_addr[i], rf_data=req_data[i],
//    rf_reg_write=(req_addr[i]!=0), and rr_ptr=(i+1) mod NUM_REQ.
//    - Latency: exactly one cycle from the accept edge to the write being presented.
//    - Throughput: one write per cycle.
//  - No transfer in a cycle: next edge loads rf_reg_write=0. rf_wr_addr and rf_data hold
//    their values.
//  - Writes to address 0 are accepted (ready given, pointer advances) and dropped: no
//    register-file write.
//  - rr_ptr changes only on a transfer. A requester that stays valid is granted within
//    NUM_REQ accepts (starvation-free).
//  - No read-port involvement. Two requesters targeting the same address are written in
//    grant order; the later grant wins.
// TESTING
//  1 Release rst -> rf_reg_write=1 on edges 1..31 with rf_wr_addr=1..31 and rf_data=0.
//    Edge 32 gives rf_reg_write=0 and init_done=1. req_ready=0 throughout.
//  2 After init, req_valid=3'b010, addr=5, data=32'hDEADBEEF -> req_ready=3'b010 in the
//    same cycle. Next cycle: rf_reg_write=1, rf_wr_addr=5, rf_data=32'hDEADBEEF.
//  3 All three requesters valid and held, rr_ptr=0 -> grants 0,1,2,0 on consecutive cycles.
//    rf_wr_addr follows each requester's address one cycle later.
//  4 Requester 0 valid with addr=0, data=7 -> req_ready[0]=1, rf_reg_write stays 0, and the
//    next grant starts from requester 1.
//  5 Assert rst for one cycle while rf_wr_addr=12 in INIT -> outputs zero. Clearing restarts
//    at address 1, and init_done rises 32 edges after release.
//  6 Assert rst in RUN during a transfer -> no write for the accepted request. INIT replays
//    in full and req_ready=0 until init_done=1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Sole owner of the register-file write port: clears x1..x(2^ADDRESS_LEN-1) after reset,
// then grants the port round-robin among NUM_REQ valid/ready write-back requesters.
module regfile_wb_arbiter #(
    parameter int ADDRESS_LEN = 5,
    parameter int N           = 32,
    parameter int NUM_REQ     = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDRESS_LEN-1:0] req_addr,
    input  logic [NUM_REQ*N-1:0]           req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rf_reg_write,
    output logic [ADDRESS_LEN-1:0]         rf_wr_addr,
    output logic [N-1:0]                   rf_data,
    output logic                           init_done
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ADDRESS_LEN-1:0] clr_cnt;
    logic                   clr_done;
    logic [PTR_W-1:0]       rr_ptr;

    logic                   grant_valid;
    logic [PTR_W-1:0]       grant_idx;
    logic [ADDRESS_LEN-1:0] grant_addr;
    logic [N-1:0]           grant_data;

    // The clear counter wraps to zero after the top address, which marks the sweep as finished.
    assign clr_done  = (clr_cnt == '0);
    assign init_done = (state == RUN);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && clr_done) begin
            state_next = RUN;
        end
    end

    // Grant search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_addr  = '0;
        grant_data  = '0;
        req_ready   = '0;
        if (state == RUN) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!grant_valid && req_valid[idx]) begin
                    grant_valid    = 1'b1;
                    grant_idx      = PTR_W'(idx);
                    grant_addr     = req_addr[idx*ADDRESS_LEN +: ADDRESS_LEN];
                    grant_data     = req_data[idx*N +: N];
                    req_ready[idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt      <= ADDRESS_LEN'(1);
            rr_ptr       <= '0;
            rf_reg_write <= 1'b0;
            rf_wr_addr   <= '0;
            rf_data      <= '0;
        end else if (state == INIT) begin
            if (!clr_done) begin
                rf_reg_write <= 1'b1;
                rf_wr_addr   <= clr_cnt;
                rf_data      <= '0;
                clr_cnt      <= clr_cnt + ADDRESS_LEN'(1);
            end else begin
                rf_reg_write <= 1'b0;
            end
        end else if (grant_valid) begin
            // x0 writes are still accepted and advance the pointer, but never reach the file.
            rf_reg_write <= (grant_addr != '0);
            rf_wr_addr   <= grant_addr;
            rf_data      <= grant_data;
            rr_ptr       <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end else begin
            rf_reg_write <= 1'b0;
        end
    end

endmodule
